// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants and helpers for the pipelined CLA adder.
//               Holds the default operand width and slice width, and the
//               stage-count calculation used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_chunk = 8;

    // Number of pipeline stages for a given operand width and slice width
    function automatic int cla_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_chunk.sv
`default_nettype none
// ============================================================================
// Module      : cla_chunk
// Description : Combinational CHUNK-bit carry-look-ahead slice. Every internal
//               carry is formed directly from the bit generate/propagate terms
//               and the slice carry-in, so no carry ripples through the slice.
//               Also exports the group propagate and group generate terms.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_chunk
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             p,
    output logic             g
);

    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK:1]   w_prop;   // w_prop[i]: bits [i-1:0] all propagate
    logic [CHUNK:1]   w_gen;    // w_gen[i]: bits [i-1:0] generate a carry
    logic [CHUNK:0]   w_c;      // w_c[i]: carry into bit i
    logic             w_term;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Sum-of-products look-ahead for every carry position
    always_comb begin
        w_prop = '0;
        w_gen  = '0;
        w_c    = '0;
        w_term = 1'b0;
        w_c[0] = ci;
        for (int i = 1; i <= CHUNK; i++) begin
            w_prop[i] = 1'b1;
            for (int k = 0; k < i; k++) begin
                w_prop[i] = w_prop[i] & w_p[k];
            end
            w_gen[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k < i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_gen[i] = w_gen[i] | w_term;
            end
            w_c[i] = w_gen[i] | (w_prop[i] & ci);
        end
    end

    assign s  = w_p ^ w_c[CHUNK-1:0];
    assign co = w_c[CHUNK];
    assign p  = w_prop[CHUNK];
    assign g  = w_gen[CHUNK];

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder_pipelined
// Description : WIDTH-bit adder built from WIDTH/CHUNK carry-look-ahead slices,
//               one slice per pipeline stage, carry registered between stages.
//               Upper operand chunks travel through skew registers and finished
//               sum chunks accumulate through de-skew registers so a complete
//               result leaves the last stage aligned. valid/ready handshake on
//               both sides; the whole pipe advances together when the output
//               register is empty or being consumed.
//               Optional macro CLA_ADDER_OVERFLOW_EN adds the 'ovf' output
//               (two's-complement overflow of the full-width addition).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_pipelined
    import cla_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CHUNK = c_default_chunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_stages = cla_stages(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_param_check
        $error("cla_adder_pipelined: WIDTH must be a multiple of CHUNK");
    end

    logic w_adv;

    // One global advance: the pipe moves whenever the output slot can be refilled
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < c_stages; k++) begin : g_stage
        logic [CHUNK-1:0]       w_a;
        logic [CHUNK-1:0]       w_b;
        logic [CHUNK-1:0]       w_s;
        logic                   w_ci;
        logic                   w_co;
        logic                   w_vin;
        logic                   w_p;
        logic                   w_g;
        logic                   w_unused_pg;
        logic [CHUNK*(k+1)-1:0] w_snext;
        logic [CHUNK*(k+1)-1:0] r_s;
        logic                   r_c;
        logic                   r_v;

        if (k == 0) begin : g_head
            assign w_a     = a[CHUNK-1:0];
            assign w_b     = b[CHUNK-1:0];
            assign w_ci    = cin;
            assign w_vin   = in_valid;
            assign w_snext = w_s;
        end else begin : g_body
            assign w_a     = g_stage[k-1].g_skew.r_a[CHUNK-1:0];
            assign w_b     = g_stage[k-1].g_skew.r_b[CHUNK-1:0];
            assign w_ci    = g_stage[k-1].r_c;
            assign w_vin   = g_stage[k-1].r_v;
            assign w_snext = {w_s, g_stage[k-1].r_s};
        end

        cla_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a  (w_a),
            .b  (w_b),
            .ci (w_ci),
            .s  (w_s),
            .co (w_co),
            .p  (w_p),
            .g  (w_g)
        );

        // The slice carry-out is registered directly; group P/G have no consumer here
        assign w_unused_pg = w_p ^ w_g;

        // Stage register: valid bit, carry to the next slice, accumulated sum chunks
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_vin;
                r_c <= w_co;
                r_s <= w_snext;
            end
        end

        if (k < c_stages - 1) begin : g_skew
            localparam int c_rest = WIDTH - CHUNK * (k + 1);
            logic [c_rest-1:0] w_a_in;
            logic [c_rest-1:0] w_b_in;
            logic [c_rest-1:0] r_a;
            logic [c_rest-1:0] r_b;

            if (k == 0) begin : g_src_port
                assign w_a_in = a[WIDTH-1:CHUNK];
                assign w_b_in = b[WIDTH-1:CHUNK];
            end else begin : g_src_prev
                assign w_a_in = g_stage[k-1].g_skew.r_a[WIDTH-CHUNK*k-1:CHUNK];
                assign w_b_in = g_stage[k-1].g_skew.r_b[WIDTH-CHUNK*k-1:CHUNK];
            end

            // Skew register: operand chunks still waiting for a later slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in;
                    r_b <= w_b_in;
                end
            end
        end
    end

    assign out_valid = g_stage[c_stages-1].r_v;
    assign sum       = g_stage[c_stages-1].r_s;
    assign cout      = g_stage[c_stages-1].r_c;

`ifdef CLA_ADDER_OVERFLOW_EN
    logic w_ovf_next;
    logic r_ovf;

    // Carry into the MSB is recovered as a^b^s at that bit; overflow when it differs from carry out
    assign w_ovf_next = (g_stage[c_stages-1].w_a[CHUNK-1] ^
                         g_stage[c_stages-1].w_b[CHUNK-1] ^
                         g_stage[c_stages-1].w_s[CHUNK-1]) ^ g_stage[c_stages-1].w_co;

    // Overflow flag registered alongside the last stage so it stays aligned with sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipelined.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cla_adder_pipelined
// Description : Self-checking bench for cla_adder_pipelined (WIDTH=32,
//               CHUNK=8): latency, directed vector table, backpressure,
//               random stream, reset mid-flight, optional overflow output
//               (CLA_ADDER_OVERFLOW_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipelined;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    int          checks    = 0;
    int          failures  = 0;
    int          rx_n      = 0;
    longint      cyc       = 0;
    longint      first_cyc = 0;
    longint      last_cyc  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    cla_adder_pipelined #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_ADDER_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every result handed to the consumer must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%0h expected none", {cout, sum});
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {31'b0, cout, sum}, {31'b0, mon_exp});
            end
            if (rx_n == 0) first_cyc = cyc;
            last_cyc = cyc;
            rx_n++;
        end
    end

    // Present one operand set, wait (bounded) for acceptance, log its expected result
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic [32:0] ex);
        int n;
        n = 0;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back(ex);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_timeout: got out_valid=0 expected 1");
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
        vecs[7] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};
        vecs[8] = '{32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1};
        vecs[9] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};

        // Reset state
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Single op: out_valid rises exactly on the 4th edge counting the accept edge
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("latency_out_valid", 64'(out_valid), (n == 4) ? 64'd1 : 64'd0);
            if (n < 4) @(posedge clk);
        end
        check("single_sum", 64'(sum), 64'h2);
        check("single_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1;

        // Directed table, streamed back-to-back
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
        end
        drain();

        // Backpressure: 4 ops in, consumer stalls for 5 cycles, then releases
        out_ready = 1'b0;
        rx_n      = 0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 33'h0_3333_3333);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 33'h1_0000_0000);
        send(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 33'h0_0001_FFFF);
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 33'h1_0000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_result", {31'b0, cout, sum}, 64'h0_3333_3333);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        check("stall_result_count", 64'(rx_n), 64'd4);

        // Random back-to-back stream
        rx_n = 0;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'b0, rc});
        end
        drain();
        check("stream_count", 64'(rx_n), 64'd100);
        check("stream_span", 64'(last_cyc - first_cyc), 64'd99);

        // Reset mid-flight: three ops accepted, then a one-cycle reset pulse
        rx_n = 0;
        send(32'h0000_0005, 32'h0000_0006, 1'b0, 33'h0_0000_000B);
        send(32'h0000_0007, 32'h0000_0008, 1'b1, 33'h0_0000_0010);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("after_reset_out_valid", 64'(out_valid), 64'd0);
        check("after_reset_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_results", 64'(rx_n), 64'd0);

`ifdef CLA_ADDER_OVERFLOW_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        wait_out();
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_set_sum", 64'(sum), 64'h8000_0000);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        wait_out();
        check("ovf_clear", 64'(ovf), 64'd0);
        check("ovf_clear_cout", 64'(cout), 64'd1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
